// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM access controller:
// controller state encoding, default widths and requester select codes.
package ram_arbiter_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant from req[1:0] and the index of
// the requester served last (0 = A, 1 = B). Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the requester not served last wins
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin access controller sharing one async-read/sync-write RAM between
// requesters A and B. Optional post-reset RAM fill enabled by RAM_CLEAR_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int            AW        = AW_DEF,
  parameter int            DW        = DW_DEF,
  parameter logic [DW-1:0] CLEAR_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

`ifdef RAM_CLEAR_EN
  localparam state_t RESET_ST = ST_CLEAR;
`else
  localparam state_t RESET_ST = ST_IDLE;
`endif

  localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};

  state_t        state;
  state_t        state_next;
  logic          last;
  logic          cmd_sel;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] clr_addr;
  logic [1:0]    arb_gnt;
  logic          accept;

  rr_arb2 u_rr_arb2 (
    .req  ({b_req, a_req}),
    .last (last),
    .gnt  (arb_gnt)
  );

  assign accept = (state == ST_IDLE) && (a_req || b_req);
  assign busy   = (state != ST_IDLE);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (a_req || b_req) state_next = ST_ACCESS;
        else                state_next = ST_IDLE;
      end
      ST_ACCESS: state_next = ST_IDLE;
      ST_CLEAR: begin
        if (clr_addr == CLR_LAST) state_next = ST_IDLE;
        else                      state_next = ST_CLEAR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // RAM port drive: address/data hold the last command, only the strobe is gated
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = cmd_addr;
    ram_din  = cmd_wdata;
    case (state)
      ST_ACCESS: ram_we = cmd_we;
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_din  = CLEAR_VAL;
      end
      default: ram_we = 1'b0;
    endcase
  end

  // State, command latch, round-robin pointer and requester-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_ST;
      last      <= SEL_B;
      cmd_sel   <= SEL_A;
      cmd_we    <= 1'b0;
      cmd_addr  <= {AW{1'b0}};
      cmd_wdata <= {DW{1'b0}};
      clr_addr  <= {AW{1'b0}};
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_rdata   <= {DW{1'b0}};
      b_rdata   <= {DW{1'b0}};
    end else begin
      state  <= state_next;
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      if (accept) begin
        last      <= arb_gnt[1];
        cmd_sel   <= arb_gnt[1];
        cmd_we    <= arb_gnt[1] ? b_we    : a_we;
        cmd_addr  <= arb_gnt[1] ? b_addr  : a_addr;
        cmd_wdata <= arb_gnt[1] ? b_wdata : a_wdata;
        a_gnt     <= arb_gnt[0];
        b_gnt     <= arb_gnt[1];
      end
      if (state == ST_ACCESS) begin
        if (cmd_sel == SEL_B) begin
          b_done <= 1'b1;
          if (!cmd_we) b_rdata <= ram_dout;
        end else begin
          a_done <= 1'b1;
          if (!cmd_we) a_rdata <= ram_dout;
        end
      end
      if (state == ST_CLEAR) clr_addr <= clr_addr + AW'(1);
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter with a behavioural 16x4 RAM
// and a transaction-level reference model (memory image, round-robin order).
module tb_ram_arbiter;

`ifdef RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int RST_LAT = CLR ? 18 : 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       preload = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = 4'h0, a_wdata = 4'h0, b_addr = 4'h0, b_wdata = 4'h0;
  logic       a_gnt, a_done, b_gnt, b_done, ram_we, busy;
  logic [3:0] a_rdata, b_rdata, ram_addr, ram_din, ram_dout;
  logic [3:0] mem [16];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] ref_mem [16];
  int         ref_last = 1;
  logic [3:0] exp_a_rdata = 4'h0;
  logic [3:0] exp_b_rdata = 4'h0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  // Behavioural RAM: async read, sync write, preload addr i with value i
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_last    = 1;
    exp_a_rdata = 4'h0;
    exp_b_rdata = 4'h0;
    if (CLR) for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
  endtask

  // Present up to two commands at once and follow them to completion
  task automatic issue(input logic [1:0] reqs, input logic [1:0] wes,
                       input logic [3:0] aa, input logic [3:0] da,
                       input logic [3:0] ab, input logic [3:0] db,
                       input int first_lat, input bit clr_window);
    logic [1:0] pending;
    int         lat, waited, who;
    bit         seen, win_we, cw;
    logic [3:0] win_addr, win_data;
    pending = reqs;
    lat     = first_lat;
    cw      = clr_window;
    @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;
    a_req = reqs[0]; a_we = wes[0]; a_addr = aa; a_wdata = da;
    b_req = reqs[1]; b_we = wes[1]; b_addr = ab; b_wdata = db;
    while (pending != 2'b00) begin
      if (pending == 2'b11) who = (ref_last == 1) ? 0 : 1;
      else                  who = pending[1] ? 1 : 0;
      win_we   = (who == 1) ? wes[1] : wes[0];
      win_addr = (who == 1) ? ab : aa;
      win_data = (who == 1) ? db : da;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < lat + 4) begin
        @(negedge clk);
        waited++;
        if (cw && waited <= 16) check_val("busy_clear", busy, 1'b1);
        if (a_gnt || b_gnt) seen = 1'b1;
      end
      check_val("gnt_latency", waited, lat);
      if (!seen) begin
        a_req = 1'b0; b_req = 1'b0;
        return;
      end
      check_val("gnt_a", a_gnt, who == 0);
      check_val("gnt_b", b_gnt, who == 1);
      check_val("ram_we", ram_we, win_we);
      check_val("ram_addr", ram_addr, win_addr);
      check_val("busy_access", busy, 1'b1);
      if (win_we) check_val("ram_din", ram_din, win_data);
      if (who == 1) b_req = 1'b0;
      else          a_req = 1'b0;
      if (win_we) ref_mem[win_addr] = win_data;
      else if (who == 1) exp_b_rdata = ref_mem[win_addr];
      else               exp_a_rdata = ref_mem[win_addr];
      @(negedge clk);
      check_val("done_a", a_done, who == 0);
      check_val("done_b", b_done, who == 1);
      check_val("rdata_a", a_rdata, exp_a_rdata);
      check_val("rdata_b", b_rdata, exp_b_rdata);
      check_val("gnt_idle", {a_gnt, b_gnt}, 2'b00);
      ref_last = who;
      pending[who] = 1'b0;
      lat = 1;
      cw  = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", {a_gnt, a_done, a_rdata, b_gnt, b_done, b_rdata}, 12'h000);
    check_val("reset_busy", busy, CLR);
    model_reset();

    // Read addr 15 pending straight out of reset
    issue(2'b01, 2'b00, 4'hF, 4'h0, 4'h0, 4'h0, RST_LAT, CLR);
    // A read addr 5 alone
    issue(2'b01, 2'b00, 4'h5, 4'h0, 4'h0, 4'h0, 2, 1'b0);
    // B write 9 <- C, then B read 9
    issue(2'b10, 2'b10, 4'h0, 4'h0, 4'h9, 4'hC, 2, 1'b0);
    issue(2'b10, 2'b00, 4'h0, 4'h0, 4'h9, 4'h0, 2, 1'b0);
    // Both requesting: alternating service
    issue(2'b11, 2'b00, 4'h2, 4'h0, 4'h9, 4'h0, 2, 1'b0);
    issue(2'b11, 2'b00, 4'h9, 4'h0, 4'h5, 4'h0, 2, 1'b0);

    // Reset lands on the ACCESS cycle of A's write to addr 3
    @(posedge clk);
    #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h3; a_wdata = 4'hA;
    repeat (2) @(negedge clk);
    check_val("rst_access_gnt", a_gnt, 1'b1);
    check_val("rst_access_we", ram_we, 1'b1);
    rst = 1'b1; a_req = 1'b0; a_we = 1'b0;
    @(negedge clk);
    check_val("rst_no_done", a_done, 1'b0);
    check_val("rst_rdata", a_rdata, 4'h0);
    check_val("rst_busy", busy, CLR);
    ref_mem[3] = 4'hA;
    model_reset();
    issue(2'b01, 2'b00, 4'h3, 4'h0, 4'h0, 4'h0, RST_LAT, CLR);

    // Randomized traffic
    repeat (80) begin
      issue(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
